// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/operand/result bundle between the control unit and seq_divider
interface seq_divider_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  seq_divider_if.slave bus
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_last_step;
  logic [XLEN-1:0] w_fin_res;

  // Operand decode at the start edge: signed ops work on magnitudes.
  assign w_signed  = ~bus.op_i[0];
  assign w_a_neg   = w_signed & bus.dividend_i[XLEN-1];
  assign w_b_neg   = w_signed & bus.divisor_i[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign w_b_mag   = w_b_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
  assign w_div0    = (bus.divisor_i == '0);
  assign w_ovf     = w_signed & (bus.dividend_i == MIN_NEG) & (bus.divisor_i == ALL_ONES);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = bus.op_i[1] ? bus.dividend_i : ALL_ONES;
    end else begin
      w_special_res = bus.op_i[1] ? '0 : MIN_NEG;
    end
  end

  // The partial remainder is always below the divisor, so XLEN bits hold it;
  // only the trial subtraction needs the extra sign bit.
  assign w_shift     = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift - {1'b0, r_dvs};
  assign w_last_step = (r_cnt == CW'(XLEN-1));

  assign w_fin_res = r_is_rem ? (r_neg_r ? (~r_rem + 1'b1) : r_rem)
                              : (r_neg_q ? (~r_quo + 1'b1) : r_quo);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i && !w_special) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_step) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_a_mag;
              r_dvs    <= w_b_mag;
              r_cnt    <= '0;
              r_is_rem <= bus.op_i[1];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIN: begin
          r_result <= w_fin_res;
          r_done   <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider: result, completion cycle and busy span per operation
module tb_seq_divider;

  localparam int XLEN = 32;
  localparam int NORM = 33;
  localparam int SPEC = 0;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   busy_run = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
    int          busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider_if #(.XLEN(XLEN)) bus ();

  seq_divider #(.XLEN(XLEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done_o pops one expected completion.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      busy_run = 0;
    end else begin
      check("busy_done_overlap", {63'd0, bus.busy_o & bus.done_o}, 64'd0);
      if (bus.busy_o) busy_run++;
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: result %0h at cycle %0d with no pending operation", bus.result_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, " result"}, {32'd0, bus.result_o}, {32'd0, mon_e.res});
          check({mon_e.name, " done_cycle"}, cyc, mon_e.at);
          check({mon_e.name, " busy_cycles"}, busy_run, mon_e.busy);
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int edges, input bit push, input string nm);
    exp_t e;
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    if (push) begin
      e.res  = res;
      e.at   = cyc + 1 + edges;
      e.busy = edges;
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk_i);
    bus.start_i    = 1'b0;
    bus.op_i       = ~op;
    bus.dividend_i = ~a;
    bus.divisor_i  = ~b;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.done_o) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: done_o not seen within %0d cycles, required by 34", nm, n);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int edges, input string nm);
    issue(op, a, b, res, edges, 1'b1, nm);
    wait_done(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.start_i    = 1'b0;
    bus.op_i       = 2'd0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (2) @(negedge clk_i);
    check("reset busy_o", {63'd0, bus.busy_o}, 64'd0);
    check("reset done_o", {63'd0, bus.done_o}, 64'd0);
    check("reset result_o", {32'd0, bus.result_o}, 64'd0);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);

    run(2'd1, 32'd100,        32'd7,        32'd14,         NORM, "DIVU 100/7");
    run(2'd3, 32'd100,        32'd7,        32'd2,          NORM, "REMU 100/7");
    run(2'd0, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  NORM, "DIV -7/2");
    run(2'd2, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  NORM, "REM -7/2");
    run(2'd0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM, "DIV 7/-2");
    run(2'd2, 32'd7,          32'hFFFF_FFFE, 32'd1,         NORM, "REM 7/-2");
    run(2'd1, 32'd5,          32'd0,        32'hFFFF_FFFF,  SPEC, "DIVU 5/0");
    run(2'd3, 32'd5,          32'd0,        32'd5,          SPEC, "REMU 5/0");
    run(2'd0, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,  SPEC, "DIV -5/0");
    run(2'd2, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB,  SPEC, "REM -5/0");
    run(2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPEC, "DIV ovf");
    run(2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SPEC, "REM ovf");
    run(2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         NORM, "DIVU 80000000/FFFFFFFF");
    run(2'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, NORM, "REMU 80000000/FFFFFFFF");

    // A second start mid-CALC (a divide-by-zero that would finish at once) must be ignored.
    issue(2'd1, 32'd1000, 32'd10, 32'd100, NORM, 1'b1, "DIVU restart");
    repeat (5) @(negedge clk_i);
    bus.start_i    = 1'b1;
    bus.op_i       = 2'd0;
    bus.dividend_i = 32'd3;
    bus.divisor_i  = 32'd0;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    wait_done("DIVU restart");
    run(2'd2, 32'd123456789, 32'd1000, 32'd789, NORM, "REM back-to-back");

    // Abort mid-CALC with an asynchronous reset; nothing may complete afterwards.
    issue(2'd1, 32'hFFFF_FFFF, 32'd3, 32'd0, NORM, 1'b0, "abort");
    repeat (9) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("abort busy_o", {63'd0, bus.busy_o}, 64'd0);
    check("abort done_o", {63'd0, bus.done_o}, 64'd0);
    check("abort result_o", {32'd0, bus.result_o}, 64'd0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    run(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORM, "DIVU after reset");

    repeat (5) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
